// File: rtl/parity_pkg.sv
// Shared types and constants for the serial parity frame checker.
package parity_pkg;

  // Receive FSM: waiting for a frame, collecting data bits, expecting parity.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  // Parity mode selectors for ODD_PARITY.
  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  // Count up on inc, stick at all-ones, clr forces zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/parity_frame_checker.sv
// Deserialises DATA_W data bits + 1 parity bit per frame, rechecks parity and
// reports each completed frame with an error flag and a saturating error count.
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int DATA_W     = 3,
  parameter bit ODD_PARITY = PAR_EVEN,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 frame_sync,
  input  logic                 clear_cnt,
  output logic [DATA_W-1:0]    frame_data,
  output logic                 frame_valid,
  output logic                 parity_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_acc;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   r_frame_data;
  logic                r_frame_valid;
  logic                r_parity_err;
  logic                r_busy;

  // frame_sync restarts the frame: a bit accepted in that cycle is bit 0.
  logic [CNT_W-1:0]    w_base_cnt;
  logic                w_base_acc;
  logic                w_par_accept;

  assign w_base_cnt   = frame_sync ? '0   : r_cnt;
  assign w_base_acc   = frame_sync ? 1'b0 : r_acc;
  assign w_par_accept = bit_valid && !frame_sync && (r_state == PAR);

  // FSM, deserialiser, parity accumulator and registered frame report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_acc         <= 1'b0;
      r_shift       <= '0;
      r_frame_data  <= '0;
      r_frame_valid <= 1'b0;
      r_parity_err  <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      if (w_par_accept) begin
        r_frame_valid <= 1'b1;
        r_frame_data  <= r_shift;
        r_parity_err  <= ((r_acc ^ bit_in) != ODD_PARITY);
        r_state       <= IDLE;
        r_cnt         <= '0;
        r_acc         <= 1'b0;
        r_busy        <= 1'b0;
      end else if (bit_valid) begin
        // Data bit: from IDLE/DATA, or bit 0 of a frame restarted by frame_sync.
        r_shift[w_base_cnt] <= bit_in;
        r_acc               <= w_base_acc ^ bit_in;
        r_cnt               <= w_base_cnt + CNT_W'(1);
        r_busy              <= 1'b1;
        if (w_base_cnt == CNT_W'(DATA_W - 1)) begin
          r_state <= PAR;
        end else begin
          r_state <= DATA;
        end
      end else if (frame_sync) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_acc   <= 1'b0;
        r_busy  <= 1'b0;
      end
    end
  end

  sat_counter #(
    .W (ERR_CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (r_frame_valid & r_parity_err),
    .clr   (clear_cnt),
    .count (err_count)
  );

  assign frame_data  = r_frame_data;
  assign frame_valid = r_frame_valid;
  assign parity_err  = r_parity_err;
  assign busy        = r_busy;

endmodule

// File: tb/tb_parity_frame_checker.sv
// Bench for parity_frame_checker: three instances (even/8-bit count,
// odd/8-bit count, even/2-bit count) share one directed stimulus stream.
module tb_parity_frame_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bit_in = 1'b0, bit_valid = 1'b0, frame_sync = 1'b0, clear_cnt = 1'b0;

  logic [2:0] fd_e, fd_o, fd_s;
  logic       fv_e, fv_o, fv_s, pe_e, pe_o, pe_s, bz_e, bz_o, bz_s;
  logic [7:0] ec_e, ec_o;
  logic [1:0] ec_s;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  parity_frame_checker #(.DATA_W(3), .ODD_PARITY(1'b0), .ERR_CNT_W(8)) u_even (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .frame_sync(frame_sync), .clear_cnt(clear_cnt), .frame_data(fd_e),
    .frame_valid(fv_e), .parity_err(pe_e), .err_count(ec_e), .busy(bz_e));

  parity_frame_checker #(.DATA_W(3), .ODD_PARITY(1'b1), .ERR_CNT_W(8)) u_odd (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .frame_sync(frame_sync), .clear_cnt(clear_cnt), .frame_data(fd_o),
    .frame_valid(fv_o), .parity_err(pe_o), .err_count(ec_o), .busy(bz_o));

  parity_frame_checker #(.DATA_W(3), .ODD_PARITY(1'b0), .ERR_CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .frame_sync(frame_sync), .clear_cnt(clear_cnt), .frame_data(fd_s),
    .frame_valid(fv_s), .parity_err(pe_s), .err_count(ec_s), .busy(bz_s));

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A frame is simply the last 4 accepted bits since reset/sync/previous frame.
  bit       q[$];
  logic     m_fv = 1'b0, m_pe = 1'b0, m_po = 1'b0, m_busy = 1'b0;
  logic [2:0] m_fd = 3'd0;
  int       m_ce = 0, m_co = 0, m_cs = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        m_fv = 0; m_fd = 0; m_pe = 0; m_po = 0; m_busy = 0;
        m_ce = 0; m_co = 0; m_cs = 0;
      end else begin
        if (clear_cnt) begin
          m_ce = 0; m_co = 0; m_cs = 0;
        end else if (m_fv) begin
          if (m_pe) begin
            m_ce = (m_ce < 255) ? m_ce + 1 : 255;
            m_cs = (m_cs < 3) ? m_cs + 1 : 3;
          end
          if (m_po) m_co = (m_co < 255) ? m_co + 1 : 255;
        end
        m_fv = 0;
        if (frame_sync) q.delete();
        if (bit_valid) q.push_back(bit_in);
        if (q.size() == 4) begin
          int ones;
          ones = 0;
          for (int k = 0; k < 4; k++) ones += int'(q[k]);
          m_fd = {q[2], q[1], q[0]};
          m_fv = 1;
          m_pe = (ones % 2) != 0;
          m_po = (ones % 2) != 1;
          q.delete();
        end
        m_busy = (q.size() != 0);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("fv_e", fv_e, m_fv);  chk("fv_o", fv_o, m_fv);  chk("fv_s", fv_s, m_fv);
      chk("fd_e", fd_e, m_fd);  chk("fd_o", fd_o, m_fd);  chk("fd_s", fd_s, m_fd);
      chk("pe_e", pe_e, m_pe);  chk("pe_o", pe_o, m_po);  chk("pe_s", pe_s, m_pe);
      chk("bz_e", bz_e, m_busy); chk("bz_o", bz_o, m_busy); chk("bz_s", bz_s, m_busy);
      chk("ec_e", ec_e, m_ce);  chk("ec_o", ec_o, m_co);  chk("ec_s", ec_s, m_cs);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input logic v, input logic b, input logic s, input logic c);
    bit_valid = v; bit_in = b; frame_sync = s; clear_cnt = c;
    @(posedge clk);
    #3;
  endtask

  task automatic send(input logic b);
    step(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [2:0] w;
    // Reset held while inputs toggle
    for (int i = 0; i < 6; i++) step(1'(i % 2), 1'((i >> 1) % 2), 1'b0, 1'b0);
    chk("rst_fv", fv_e, 0); chk("rst_fd", fd_e, 0); chk("rst_pe", pe_e, 0);
    chk("rst_ec", ec_e, 0); chk("rst_busy", bz_e, 0); chk("rst_ec_s", ec_s, 0);
    rst_n = 1'b1;
    idle();

    // 1,0,1 parity 0
    send(1); send(0); send(1); send(0);
    chk("t2_fv", fv_e, 1); chk("t2_fd", fd_e, 5); chk("t2_pe", pe_e, 0); chk("t2_pe_odd", pe_o, 1);
    idle();
    chk("t2_pulse_end", fv_e, 0); chk("t2_ec", ec_e, 0); chk("t2_ec_odd", ec_o, 1);

    // all 8 words with correct even parity
    for (int i = 0; i < 8; i++) begin
      w = 3'(i);
      for (int k = 0; k < 3; k++) send(w[k]);
      send(^w);
      idle();
    end
    chk("all_ec", ec_e, 0); chk("all_ec_odd", ec_o, 9);

    // 1,1,1 parity 0: bad for even, good for odd
    send(1); send(1); send(1); send(0);
    chk("t3_fd", fd_e, 7); chk("t3_pe", pe_e, 1); chk("t3_pe_odd", pe_o, 0);
    idle();
    chk("t3_ec", ec_e, 1); chk("t3_ec_s", ec_s, 1); chk("t3_ec_odd", ec_o, 9);

    // gaps of 2 cycles between bits, then back-to-back frame
    send(0); idle(); idle(); send(1); idle(); idle();
    send(1); idle(); idle(); send(0);
    chk("t4_fv", fv_e, 1); chk("t4_fd", fd_e, 6); chk("t4_pe", pe_e, 0);
    send(1); send(0); send(0); send(1);
    chk("t4b_fv", fv_e, 1); chk("t4b_fd", fd_e, 1); chk("t4b_pe", pe_e, 0); chk("t4b_busy", bz_e, 0);

    // frame_sync mid-data restarts with the same-cycle bit as bit 0
    send(1); send(1); step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("t5_busy", bz_e, 1);
    send(1); send(1); send(0);
    chk("t5_fv", fv_e, 1); chk("t5_fd", fd_e, 6);

    // frame_sync while parity expected suppresses completion
    send(1); send(0); send(1); step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("sync_par_fv", fv_e, 0); chk("sync_par_busy", bz_e, 1);
    send(0); send(0); send(0);
    chk("sync_par_fv2", fv_e, 1); chk("sync_par_fd", fd_e, 0);
    idle();
    chk("sync_ec", ec_e, 1); chk("sync_ec_odd", ec_o, 13);

    // reset after two bits drops the partial frame
    send(1); send(1);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", bz_e, 0); chk("mrst_fd", fd_e, 0); chk("mrst_ec_odd", ec_o, 0);
    idle();
    rst_n = 1'b1;
    send(1); send(0);
    chk("mrst_nopulse", fv_e, 0); chk("mrst_busy2", bz_e, 1);
    send(1); send(0);
    chk("mrst_fv", fv_e, 1); chk("mrst_fd", fd_e, 5);
    idle();

    // saturation of the 2-bit counter, then clear beating increment
    for (int n = 0; n < 4; n++) begin
      send(1); send(1); send(1); send(0); idle();
    end
    chk("sat_ec_s", ec_s, 3); chk("sat_ec_e", ec_e, 4);
    send(1); send(1); send(1); send(0);
    chk("clr_fv", fv_e, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_ec_s", ec_s, 0); chk("clr_ec_e", ec_e, 0); chk("clr_ec_o", ec_o, 0);
    idle();
    chk("clr_hold", ec_s, 0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
